// File: rtl/stage_f.sv
// Fetch stage: owns the PC, issues word requests on a req/gnt/rvalid bus and
// buffers in-order responses so decode sees a stable instruction while stalled.
module stage_f #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          DEPTH           = 2,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] NOP_INSTR       = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   input  logic        PCSrcW,
   input  logic [31:0] ResultW,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] RDD,
   output logic [31:0] PCF,
   output logic [31:0] PCPlus4F,
   output logic        InstrValidF
);

   localparam int QW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(DEPTH + MAX_OUTSTANDING + 1);

   logic [31:0]   fetch_pc_reg, fetch_pc_next;
   logic [CW-1:0] occ_reg, occ_next;
   logic [CW-1:0] outst_reg, outst_next;
   logic [CW-1:0] drop_reg, drop_next;
   logic [QW-1:0] head_reg, head_next, tail_reg, tail_next;
   logic [OW-1:0] pf_rd_reg, pf_rd_next, pf_wr_reg, pf_wr_next;

   logic [31:0] q_pc    [DEPTH];
   logic [31:0] q_instr [DEPTH];
   logic [31:0] pf_pc   [MAX_OUTSTANDING];

   logic        redirect, fire, resp, discard, push, pop;
   logic [31:0] target, expect_pc;
   int          exp_idx;

   function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
      return (p == QW'(DEPTH - 1)) ? '0 : p + QW'(1);
   endfunction

   function automatic logic [OW-1:0] pf_inc(input logic [OW-1:0] p);
      return (p == OW'(MAX_OUTSTANDING - 1)) ? '0 : p + OW'(1);
   endfunction

   always_comb begin
      redirect  = PCSrcW | PCSrcE;
      target    = {(PCSrcW ? ResultW[31:2] : PCTargetE[31:2]), 2'b00};
      // Counting queued plus in-flight words guarantees every response a slot.
      imem_req  = rst && !redirect
                  && (outst_reg < CW'(MAX_OUTSTANDING))
                  && ((occ_reg + outst_reg) < CW'(DEPTH));
      imem_addr = fetch_pc_reg;
      fire      = imem_req && imem_gnt;
      resp      = imem_rvalid && (outst_reg != '0);
      discard   = resp && (redirect || (drop_reg != '0));
      push      = resp && !discard;
      pop       = (occ_reg != '0) && !StallF && !redirect;

      outst_next = outst_reg + CW'(fire) - CW'(resp);
      pf_wr_next = fire ? pf_inc(pf_wr_reg) : pf_wr_reg;
      pf_rd_next = resp ? pf_inc(pf_rd_reg) : pf_rd_reg;

      if (redirect) begin
         fetch_pc_next = target;
         occ_next      = '0;
         head_next     = '0;
         tail_next     = '0;
         drop_next     = outst_next;
      end else begin
         fetch_pc_next = fire ? fetch_pc_reg + 32'd4 : fetch_pc_reg;
         occ_next      = occ_reg + CW'(push) - CW'(pop);
         head_next     = pop ? q_inc(head_reg) : head_reg;
         tail_next     = push ? q_inc(tail_reg) : tail_reg;
         drop_next     = (resp && (drop_reg != '0)) ? drop_reg - CW'(1) : drop_reg;
      end
   end

   // Stale requests are always the oldest ones, so the first live PC sits
   // 'drop' entries past the read pointer of the issued-PC FIFO.
   always_comb begin
      exp_idx = int'(pf_rd_reg) + int'(drop_reg);
      if (exp_idx >= MAX_OUTSTANDING)
         exp_idx = exp_idx - MAX_OUTSTANDING;
      expect_pc   = (outst_reg > drop_reg) ? pf_pc[OW'(exp_idx)] : fetch_pc_reg;
      InstrValidF = (occ_reg != '0);
      RDD         = InstrValidF ? q_instr[head_reg] : NOP_INSTR;
      PCF         = InstrValidF ? q_pc[head_reg] : expect_pc;
      PCPlus4F    = PCF + 32'd4;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_reg <= RESET_PC;
         occ_reg      <= '0;
         outst_reg    <= '0;
         drop_reg     <= '0;
         head_reg     <= '0;
         tail_reg     <= '0;
         pf_rd_reg    <= '0;
         pf_wr_reg    <= '0;
      end else begin
         fetch_pc_reg <= fetch_pc_next;
         occ_reg      <= occ_next;
         outst_reg    <= outst_next;
         drop_reg     <= drop_next;
         head_reg     <= head_next;
         tail_reg     <= tail_next;
         pf_rd_reg    <= pf_rd_next;
         pf_wr_reg    <= pf_wr_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[tail_reg]    <= pf_pc[pf_rd_reg];
         q_instr[tail_reg] <= imem_rdata;
      end
      if (fire)
         pf_pc[pf_wr_reg] <= fetch_pc_reg;
   end

   // A response with nothing in flight is a bus protocol violation.
   assert property (@(posedge clk) disable iff (!rst)
                    !(imem_rvalid && (outst_reg == '0)));

endmodule
